// File: rtl/wc_pkg.sv
// Shared constants, sample type and tile packing helper for the wc tiler.
// Element i of an n-element bus sits at bit offset (n-1-i)*DW, element 0 at the MSB.
package wc_pkg;

  localparam int DW     = 10;
  localparam int M      = 3;
  localparam int R      = 3;
  localparam int T      = M + R - 1;
  localparam int WC_LAT = 6;
  localparam int CW     = $clog2(WC_LAT + 1);

  typedef logic signed [DW-1:0] sample_t;

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    DRAIN
  } state_e;

  function automatic int elem_off(input int n, input int i);
    return (n - 1 - i) * DW;
  endfunction

endpackage

// File: rtl/wc_window.sv
// T-entry sample window: write-at-index, zero-pad-from-index, shift-by-M and clear.
// Exposes its next-state contents so a tile can be captured in the same cycle it completes.
module wc_window
  import wc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [2:0]      wr_idx,
  input  sample_t         wr_data,
  input  logic            pad_en,
  input  logic [2:0]      pad_idx,
  input  logic            shift_en,
  input  logic            clr,
  output logic [T*DW-1:0] win_nxt
);

  sample_t win_q [T];
  sample_t win_d [T];

  always_comb begin
    // NOTE: every entry takes its held value first, so no path leaves win_d unassigned (no latch).
    for (int i = 0; i < T; i++) win_d[i] = win_q[i];
    if (clr) begin
      for (int i = 0; i < T; i++) win_d[i] = '0;
    end else if (shift_en) begin
      for (int i = 0; i < T - M; i++) win_d[i] = win_q[i + M];
      for (int i = T - M; i < T; i++) win_d[i] = '0;
    end else begin
      if (pad_en) begin
        for (int i = 0; i < T; i++) begin
          if (3'(i) >= pad_idx) win_d[i] = '0;
        end
      end
      if (wr_en) win_d[wr_idx] = wr_data;
    end
  end

  always_comb begin
    win_nxt = '0;
    for (int i = 0; i < T; i++) win_nxt[elem_off(T, i) +: DW] = win_d[i];
  end

  // NOTE: the window is only five registers and must read as zero after reset, so each entry is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < T; i++) win_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      for (int i = 0; i < T; i++) win_q[i] <= win_d[i];
    end
  end

endmodule

// File: rtl/wc_tiler.sv
// Cuts a sample row into overlapping 5-sample tiles for the wc core, waits its latency,
// then serialises the 3-element result with row framing.
module wc_tiler
  import wc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  input  logic            s_last,
  output logic [T*DW-1:0] wc_d,
  input  logic [M*DW-1:0] wc_z,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  output logic            row_err
);

  state_e          state_q, state_d;
  logic [2:0]      fill_q, fill_p1;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      nvalid_q, idx_q;
  logic            row_end_q, s_ready_q;
  sample_t         res_q [M];
  logic            win_wr, win_pad, win_shift, win_clr;
  logic            load_tile, short_row, capture, xfer, last_xfer;
  logic [T*DW-1:0] win_nxt;

  assign fill_p1   = fill_q + 3'd1;
  assign last_xfer = (idx_q == nvalid_q - 2'd1);

  wc_window u_window (
    .clk      (clk),
    .rst_n    (rst),
    .wr_en    (win_wr),
    .wr_idx   (fill_q),
    .wr_data  (s_data),
    .pad_en   (win_pad),
    .pad_idx  (fill_p1),
    .shift_en (win_shift),
    .clr      (win_clr),
    .win_nxt  (win_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    win_wr    = 1'b0;
    win_pad   = 1'b0;
    win_shift = 1'b0;
    win_clr   = 1'b0;
    load_tile = 1'b0;
    short_row = 1'b0;
    capture   = 1'b0;
    xfer      = 1'b0;
    case (state_q)
      FILL: begin
        if (s_valid && s_ready_q) begin
          win_wr = 1'b1;
          if (s_last && fill_p1 < 3'(R)) begin
            short_row = 1'b1;
            win_clr   = 1'b1;
          end else if (s_last || fill_p1 == 3'(T)) begin
            load_tile = 1'b1;
            win_pad   = s_last;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == CW'(1)) begin
          capture = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          xfer = 1'b1;
          if (last_xfer) begin
            // End of row restarts clean; mid-row keeps the two-sample overlap.
            win_clr   = row_end_q;
            win_shift = !row_end_q;
            state_d   = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q    <= '0;
      cnt_q     <= '0;
      nvalid_q  <= '0;
      idx_q     <= '0;
      row_end_q <= 1'b0;
      s_ready_q <= 1'b0;
      row_err   <= 1'b0;
      wc_d      <= '0;
      for (int i = 0; i < M; i++) res_q[i] <= '0;
    end else begin
      s_ready_q <= (state_d == FILL);
      row_err   <= short_row;
      if (win_wr)                 fill_q <= short_row ? 3'd0 : fill_p1;
      else if (xfer && last_xfer) fill_q <= row_end_q ? 3'd0 : 3'(T - M);
      if (load_tile) begin
        wc_d      <= win_nxt;
        cnt_q     <= CW'(WC_LAT);
        nvalid_q  <= 2'(fill_p1 - 3'd2);
        row_end_q <= s_last;
        idx_q     <= '0;
      end else if (state_q == HOLD) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (capture) begin
        for (int i = 0; i < M; i++) res_q[i] <= wc_z[elem_off(M, i) +: DW];
      end
      if (xfer) idx_q <= idx_q + 2'd1;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = (state_q == DRAIN);
  assign m_data  = m_valid ? res_q[idx_q] : '0;
  assign m_last  = m_valid && row_end_q && last_xfer;

endmodule
